bram_arbiter: RTL and testbench

Two-master arbiter that shares one single-port `bram` instance between two bus requesters, for example a CPU instruction port and a DMA/data port. It accepts requests on two master-side `sel`/`ack` ports and grants one at a time. It then drives the slave-side `bram` port and routes the slave's `ack_o` and `data_out_o` back to the granted master. It sits between the requesters and `bram` in the SoC memory map.

---
 rtl/bram_arb_pkg.sv | 8 +
 rtl/bram_arb_select.sv | 22 ++
 rtl/bram_arbiter.sv | 95 +++++++++
 tb/tb_bram_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-master bram arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;

  localparam int NUM_MASTERS = 2;

endpackage

// File: rtl/bram_arb_select.sv
// Combinational winner pick for the bram arbiter.
// Macro: BRAM_ARB_ROUND_ROBIN_EN selects round-robin pointer update; otherwise fixed m0 priority.
module bram_arb_select
  import bram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   ptr,
  output logic                   win,
  output logic                   ptr_next
);

  always_comb begin
    // Ties go to the master named by ptr; a lone requester always wins.
    win = (req[0] && req[1]) ? ptr : req[1];
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    ptr_next = ~win;
`else
    ptr_next = 1'b0;
`endif
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-master arbiter sharing one single-port bram: IDLE -> ISSUE -> WAIT FSM.
// Macro: BRAM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (see bram_arb_select).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              m0_sel_i,
  input  logic              m1_sel_i,
  input  logic              m0_wr_en_i,
  input  logic              m1_wr_en_i,
  input  logic [3:0]        m0_wr_mask_i,
  input  logic [3:0]        m1_wr_mask_i,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic [31:0]       m0_data_i,
  input  logic [31:0]       m1_data_i,
  output logic [31:0]       m0_data_o,
  output logic [31:0]       m1_data_o,
  output logic              m0_ack_o,
  output logic              m1_ack_o,
  output logic              s_sel_o,
  output logic              s_wr_en_o,
  output logic [3:0]        s_wr_mask_o,
  output logic [ADDR_W-1:0] s_address_o,
  output logic [31:0]       s_data_o,
  input  logic [31:0]       s_data_i,
  input  logic              s_ack_i
);

  arb_state_t             state;
  logic                   grant;
  logic                   ptr;
  logic                   win;
  logic                   ptr_next;
  logic                   done;
  logic [NUM_MASTERS-1:0] req;

  assign req = {m1_sel_i, m0_sel_i};

  bram_arb_select u_select (
    .req      (req),
    .ptr      (ptr),
    .win      (win),
    .ptr_next (ptr_next)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= ARB_IDLE;
      grant       <= 1'b0;
      ptr         <= 1'b0;
      s_sel_o     <= 1'b0;
      s_wr_en_o   <= 1'b0;
      s_wr_mask_o <= '0;
      s_address_o <= '0;
      s_data_o    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant       <= win;
            ptr         <= ptr_next;
            s_sel_o     <= 1'b1;
            s_wr_en_o   <= win ? m1_wr_en_i   : m0_wr_en_i;
            s_wr_mask_o <= win ? m1_wr_mask_i : m0_wr_mask_i;
            s_address_o <= win ? m1_address_i : m0_address_i;
            s_data_o    <= win ? m1_data_i    : m0_data_i;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          s_sel_o <= 1'b0;
          state   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (s_ack_i) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Slave acks outside WAIT are stale and never reach a master.
  always_comb begin
    done      = (state == ARB_WAIT) && s_ack_i;
    m0_ack_o  = done && !grant;
    m1_ack_o  = done && grant;
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter with a behavioural 16-word bram and a reference memory/arbitration model.
module tb_bram_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          m0_sel_i, m1_sel_i, m0_wr_en_i, m1_wr_en_i;
  logic [3:0]    m0_wr_mask_i, m1_wr_mask_i;
  logic [AW-1:0] m0_address_i, m1_address_i;
  logic [31:0]   m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic          m0_ack_o, m1_ack_o;
  logic          s_sel_o, s_wr_en_o, s_ack_i;
  logic [3:0]    s_wr_mask_o;
  logic [AW-1:0] s_address_o;
  logic [31:0]   s_data_o, s_data_i;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_sel_i(m0_sel_i), .m1_sel_i(m1_sel_i),
    .m0_wr_en_i(m0_wr_en_i), .m1_wr_en_i(m1_wr_en_i),
    .m0_wr_mask_i(m0_wr_mask_i), .m1_wr_mask_i(m1_wr_mask_i),
    .m0_address_i(m0_address_i), .m1_address_i(m1_address_i),
    .m0_data_i(m0_data_i), .m1_data_i(m1_data_i),
    .m0_data_o(m0_data_o), .m1_data_o(m1_data_o),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .s_sel_o(s_sel_o), .s_wr_en_o(s_wr_en_o), .s_wr_mask_o(s_wr_mask_o),
    .s_address_o(s_address_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  // Behavioural bram, SIZE=16: registered ack and pre-write read data one cycle after sel.
  logic [31:0] bmem [16];
  logic        b_ack = 1'b0;
  logic [31:0] b_data = '0;
  logic        force_ack = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  assign s_ack_i  = b_ack | force_ack;
  assign s_data_i = b_data;

  always @(posedge clk) begin
    b_ack <= s_sel_o;
    if (load_en) bmem[load_addr] <= load_data;
    else if (s_sel_o) begin
      b_data <= bmem[s_address_o[3:0]];
      if (s_wr_en_o)
        for (int b = 0; b < 4; b++)
          if (s_wr_mask_o[b]) bmem[s_address_o[3:0]][8*b +: 8] <= s_data_o[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] ref_mem [16];
  int          last_win;
  int          compared = 0, mismatched = 0;
  logic        f_we [2];
  logic [3:0]  f_mk [2];
  logic [31:0] f_ad [2];
  logic [31:0] f_dt [2];
  logic [31:0] last_rd;
  int          ack_cyc_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic sel);
    if (m == 0) begin
      m0_sel_i = sel; m0_wr_en_i = f_we[0]; m0_wr_mask_i = f_mk[0];
      m0_address_i = f_ad[0]; m0_data_i = f_dt[0];
    end else begin
      m1_sel_i = sel; m1_wr_en_i = f_we[1]; m1_wr_mask_i = f_mk[1];
      m1_address_i = f_ad[1]; m1_data_i = f_dt[1];
    end
  endtask

  function automatic int tie_win();
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    return 1 - last_win;
`else
    return 0;
`endif
  endfunction

  task automatic model_access(input int m, output logic [31:0] rd);
    logic [3:0] a;
    a  = f_ad[m][3:0];
    rd = ref_mem[a];
    if (f_we[m])
      for (int b = 0; b < 4; b++)
        if (f_mk[m][b]) ref_mem[a][8*b +: 8] = f_dt[m][8*b +: 8];
    last_win = m;
  endtask

  // One request (or a simultaneous pair); each master drops sel the cycle after its ack.
  task automatic run(input bit use0, input bit use1);
    int          n, got;
    int          em [2];
    logic [31:0] ed [2];
    if (use0 && use1) begin
      em[0] = tie_win(); em[1] = 1 - em[0]; n = 2;
    end else begin
      em[0] = use1 ? 1 : 0; em[1] = 0; n = 1;
    end
    for (int k = 0; k < n; k++) model_access(em[k], ed[k]);
    if (use0) drive(0, 1'b1);
    if (use1) drive(1, 1'b1);
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      if (c == 1) check("issue_sel", s_sel_o, 1);
      if (m0_ack_o || m1_ack_o) begin
        check("ack_cycle", c, (got == 0) ? 2 : 5);
        check("ack_master", m1_ack_o, em[got]);
        check("ack_onehot", m0_ack_o ^ m1_ack_o, 1);
        last_rd = m1_ack_o ? m1_data_o : m0_data_o;
        check("rdata", last_rd, ed[got]);
        ack_cyc_last = cyc;
        @(posedge clk); #1;
        drive(em[got], 1'b0);
        got++;
      end
    end
    check("ack_count", got, n);
  endtask

  initial begin
    int          t0, prev, w, lat;
    bit          found;
    logic [31:0] exp;

    reset_i = 1'b1;
    for (int m = 0; m < 2; m++) begin
      f_we[m] = 1'b0; f_mk[m] = '0; f_ad[m] = '0; f_dt[m] = '0;
      drive(m, 1'b0);
    end
    last_win = 1;
    @(posedge clk); #1;
    load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = (i == 3) ? 32'hDEADBEEF : (i == 5) ? 32'h0 : $urandom;
      load_addr = i[3:0]; load_data = ref_mem[i];
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    @(negedge clk);
    check("rst_s_sel", s_sel_o, 0);
    check("rst_s_wr_en", s_wr_en_o, 0);
    check("rst_s_wr_mask", s_wr_mask_o, 0);
    check("rst_s_address", s_address_o, 0);
    check("rst_s_data", s_data_o, 0);
    check("rst_m0_ack", m0_ack_o, 0);
    check("rst_m1_ack", m1_ack_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    // Single read
    f_we[0] = 1'b0; f_ad[0] = 32'd3;
    run(1'b1, 1'b0);
    check("single_read", last_rd, 32'hDEADBEEF);

    // Masked write then read
    f_we[1] = 1'b1; f_mk[1] = 4'b0101; f_ad[1] = 32'd5; f_dt[1] = 32'h11223344;
    run(1'b0, 1'b1);
    f_we[1] = 1'b0;
    run(1'b0, 1'b1);
    check("masked_read", last_rd, 32'h00220044);

    // Back-to-back reads from m0
    f_we[0] = 1'b0; f_ad[0] = 32'd3;
    run(1'b1, 1'b0);
    t0 = ack_cyc_last;
    f_ad[0] = 32'd5;
    run(1'b1, 1'b0);
    check("b2b_spacing", ack_cyc_last - t0, 3);

    // Both masters hold sel continuously
    f_we[0] = 1'b0; f_ad[0] = 32'd3;
    f_we[1] = 1'b0; f_ad[1] = 32'd5;
    drive(0, 1'b1); drive(1, 1'b1);
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      w = tie_win();
      model_access(w, exp);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (m0_ack_o || m1_ack_o) begin
          found = 1'b1;
          check("hold_master", m1_ack_o, w);
          check("hold_onehot", m0_ack_o ^ m1_ack_o, 1);
          check("hold_rdata", m1_ack_o ? m1_data_o : m0_data_o, exp);
          if (prev >= 0) check("hold_spacing", cyc - prev, 3);
          prev = cyc;
        end
      end
      check("hold_found", found, 1);
    end
    @(posedge clk); #1;
    drive(0, 1'b0); drive(1, 1'b0);

    // Randomized traffic, single and simultaneous
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++) begin
        f_we[m] = 1'($urandom_range(0, 1));
        f_mk[m] = 4'($urandom_range(0, 15));
        f_ad[m] = $urandom_range(0, 15);
        f_dt[m] = $urandom;
      end
      case ($urandom_range(0, 2))
        0:       run(1'b1, 1'b0);
        1:       run(1'b0, 1'b1);
        default: run(1'b1, 1'b1);
      endcase
    end

    // Reset asserted during the ISSUE cycle
    f_we[0] = 1'b0; f_ad[0] = 32'd3;
    drive(0, 1'b1);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_mid_issue_sel", s_sel_o, 1);
    @(posedge clk); #1;
    reset_i = 1'b0;
    last_win = 1;
    @(negedge clk);
    check("rst_mid_sel", s_sel_o, 0);
    check("rst_mid_m0_ack", m0_ack_o, 0);
    check("rst_mid_m1_ack", m1_ack_o, 0);
    model_access(0, exp);
    lat = -1;
    for (int c = 1; c < 12 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) check("rst_reissue_sel", s_sel_o, 1);
      if (m0_ack_o || m1_ack_o) begin
        lat = c;
        check("rst_ack_m0", m0_ack_o, 1);
        check("rst_rdata", m0_data_o, exp);
      end
    end
    check("rst_latency", lat, 2);
    @(posedge clk); #1;
    drive(0, 1'b0);

    // Stale slave ack in IDLE
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(negedge clk);
    check("stale_m0_ack", m0_ack_o, 0);
    check("stale_m1_ack", m1_ack_o, 0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("stale_no_issue", s_sel_o, 0);
    @(posedge clk); #1;
    f_we[1] = 1'b0; f_ad[1] = 32'd5;
    run(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
